// File: rtl/rv32i_pkg.sv
// Shared RV32I types: immediate formats and the lane ids used by the immediate arbiter.
package rv32i_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_t;

    localparam int NUM_IMM_LANES = 2;

    typedef logic lane_id_t;

endpackage

// File: rtl/imm_share_arb_if.sv
// Per-lane request/response bundle between the two requesting lanes and imm_share_arb.
interface imm_share_arb_if #(parameter int TAG_W = 4);
    import rv32i_pkg::*;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][31:0]      req_instr;
    imm_t [1:0]            req_sel;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [1:0][31:0]      rsp_imm;
    logic [1:0][TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_instr, req_sel, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_imm, rsp_tag
    );

    modport slave (
        input  req_valid, req_instr, req_sel, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_imm, rsp_tag
    );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: extracts and extends the immediate of one instruction word.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_t        sel_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = 32'h0;
        case (sel_i)
            IMM_I: imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
            IMM_S: imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'h000};
            IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z: imm_o = {27'h0, instr_i[19:15]};
            default: imm_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/imm_share_arb.sv
// Shares one imm_gen between the decode lane (0) and the early-branch lane (1);
// each lane gets a one-entry registered response buffer.
module imm_share_arb
    import rv32i_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int FAIR  = 1
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           conflict,
    imm_share_arb_if.slave bus
);

    logic [1:0]            elig;
    logic [1:0]            grant;
    lane_id_t              gnt_lane;
    logic [31:0]           gen_imm;

    logic [1:0]            rsp_valid_q;
    logic [1:0][31:0]      rsp_imm_q;
    logic [1:0][TAG_W-1:0] rsp_tag_q;
    lane_id_t              last_grant_q;

    always_comb begin
        elig  = 2'b00;
        grant = 2'b00;
        for (int i = 0; i < NUM_IMM_LANES; i++) begin
            elig[i] = bus.req_valid[i] & ~flush & (~rsp_valid_q[i] | bus.rsp_ready[i]);
        end
        // Lane 0 wins ties after reset because last_grant resets to lane 1.
        if (&elig) begin
            if ((FAIR != 0) && (last_grant_q == 1'b0)) grant = 2'b10;
            else                                       grant = 2'b01;
        end else begin
            grant = elig;
        end
        grant = grant & {2{rst_n}};
    end

    assign conflict      = (&elig) & rst_n;
    assign bus.req_ready = grant;
    assign gnt_lane      = lane_id_t'(grant[1]);

    imm_gen u_imm_gen (
        .instr_i (bus.req_instr[gnt_lane]),
        .sel_i   (bus.req_sel[gnt_lane]),
        .imm_o   (gen_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 2'b00;
            rsp_imm_q    <= '0;
            rsp_tag_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_IMM_LANES; i++) begin
                if (flush) begin
                    rsp_valid_q[i] <= 1'b0;
                end else if (grant[i]) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_imm_q[i]   <= gen_imm;
                    rsp_tag_q[i]   <= bus.req_tag[i];
                end else if (bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
            if (|grant) last_grant_q <= gnt_lane;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_imm   = rsp_imm_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_imm_share_arb.sv
// Scoreboard bench: one FAIR=1 and one FAIR=0 arbiter driven side by side against a
// behavioural model of the lane rules and RV32I immediate arithmetic.
module tb_imm_share_arb;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] imm;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_v = 1'b0;

    logic [1:0]       valid_v [2];
    logic [1:0][31:0] instr_v [2];
    imm_t [1:0]       sel_v   [2];
    logic [1:0][3:0]  tag_v   [2];
    logic [1:0]       rdy_v   [2];

    logic [1:0]       rr_o [2];
    logic [1:0]       rv_o [2];
    logic [1:0][31:0] ri_o [2];
    logic [1:0][3:0]  rt_o [2];
    logic [1:0]       cf_o;

    logic [1:0] full [2];
    logic [1:0] last;
    logic [1:0] held [2];
    exp_t       expq [4][$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_share_arb_if #(.TAG_W(4)) if0 ();
    imm_share_arb_if #(.TAG_W(4)) if1 ();

    assign if0.req_valid = valid_v[0];
    assign if0.req_instr = instr_v[0];
    assign if0.req_sel   = sel_v[0];
    assign if0.req_tag   = tag_v[0];
    assign if0.rsp_ready = rdy_v[0];
    assign if1.req_valid = valid_v[1];
    assign if1.req_instr = instr_v[1];
    assign if1.req_sel   = sel_v[1];
    assign if1.req_tag   = tag_v[1];
    assign if1.rsp_ready = rdy_v[1];

    assign rr_o[0] = if0.req_ready;
    assign rv_o[0] = if0.rsp_valid;
    assign ri_o[0] = if0.rsp_imm;
    assign rt_o[0] = if0.rsp_tag;
    assign rr_o[1] = if1.req_ready;
    assign rv_o[1] = if1.rsp_valid;
    assign ri_o[1] = if1.rsp_imm;
    assign rt_o[1] = if1.rsp_tag;

    imm_share_arb #(.TAG_W(4), .FAIR(1)) u_fair (
        .clk(clk), .rst_n(rst_n), .flush(flush_v), .conflict(cf_o[0]), .bus(if0.slave)
    );

    imm_share_arb #(.TAG_W(4), .FAIR(0)) u_prio (
        .clk(clk), .rst_n(rst_n), .flush(flush_v), .conflict(cf_o[1]), .bus(if1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp_v);
        end
    endtask

    // Immediate value built arithmetically from the field weights.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
        logic [31:0] r;
        case (sel)
            3'd0: r = (ins[31] ? 32'hFFFFF800 : 32'h0) + 32'(ins[30:20]);
            3'd1: r = (ins[31] ? 32'hFFFFF800 : 32'h0) + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:7]);
            3'd2: r = (ins[31] ? 32'hFFFFF000 : 32'h0) + 32'(ins[7]) * 32'd2048
                      + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
            3'd3: r = ins & 32'hFFFFF000;
            3'd4: r = (ins[31] ? 32'hFFF00000 : 32'h0) + 32'(ins[19:12]) * 32'd4096
                      + 32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2;
            3'd5: r = 32'(ins[19:15]);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            full[d] = 2'b00;
            held[d] = 2'b00;
        end
        last = 2'b11;
        for (int k = 0; k < 4; k++) expq[k].delete();
    endtask

    // Inputs are already set for this cycle; evaluate the model and wait for the next negedge.
    task automatic cycle();
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [1:0] el;
            logic [1:0] g;
            for (int i = 0; i < 2; i++)
                el[i] = valid_v[d][i] & ~flush_v & (~full[d][i] | rdy_v[d][i]);
            if (el == 2'b11) g = (d == 0 && last[d] == 1'b0) ? 2'b10 : 2'b01;
            else             g = el;
            chk($sformatf("req_ready_dut%0d", d), 32'(rr_o[d]), 32'(g));
            chk($sformatf("conflict_dut%0d", d), 32'(cf_o[d]), 32'(&el));
            chk($sformatf("rsp_valid_dut%0d", d), 32'(rv_o[d]), 32'(full[d]));
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    exp_t e;
                    e.imm = ref_imm(instr_v[d][i], 3'(sel_v[d][i]));
                    e.tag = tag_v[d][i];
                    expq[d*2+i].push_back(e);
                    full[d][i] = 1'b1;
                    last[d] = (i == 1);
                end else if (flush_v) begin
                    full[d][i] = 1'b0;
                    expq[d*2+i].delete();
                end else if (rdy_v[d][i]) begin
                    full[d][i] = 1'b0;
                end
            end
            held[d] = valid_v[d] & ~g;
        end
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] ins, input imm_t s,
                         input logic [3:0] t);
        for (int d = 0; d < 2; d++) begin
            valid_v[d][i] = v;
            instr_v[d][i] = ins;
            sel_v[d][i]   = s;
            tag_v[d][i]   = t;
        end
    endtask

    task automatic set_rdy(input logic [1:0] r);
        rdy_v[0] = r;
        rdy_v[1] = r;
    endtask

    // Monitor: whenever a buffer is drained, its contents must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 2; i++) begin
                        if (rv_o[d][i] && rdy_v[d][i]) begin
                            if (expq[d*2+i].size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL rsp_unexpected dut%0d lane%0d t=%0t actual=%h required=none",
                                         d, i, $time, ri_o[d][i]);
                            end else begin
                                exp_t e;
                                e = expq[d*2+i].pop_front();
                                chk($sformatf("rsp_imm_dut%0d_lane%0d", d, i), ri_o[d][i], e.imm);
                                chk($sformatf("rsp_tag_dut%0d_lane%0d", d, i), 32'(rt_o[d][i]), 32'(e.tag));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        for (int d = 0; d < 2; d++) begin
            valid_v[d] = 2'b11;
            instr_v[d] = '0;
            sel_v[d]   = {IMM_I, IMM_I};
            tag_v[d]   = '0;
            rdy_v[d]   = 2'b00;
        end

        // Reset state, with requests pending to show req_ready is held low.
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rsp_valid_dut%0d", d), 32'(rv_o[d]), 32'h0);
            chk($sformatf("rst_rsp_imm0_dut%0d", d), ri_o[d][0], 32'h0);
            chk($sformatf("rst_rsp_imm1_dut%0d", d), ri_o[d][1], 32'h0);
            chk($sformatf("rst_rsp_tag_dut%0d", d), 32'(rt_o[d]), 32'h0);
            chk($sformatf("rst_req_ready_dut%0d", d), 32'(rr_o[d]), 32'h0);
            chk($sformatf("rst_conflict_dut%0d", d), 32'(cf_o[d]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Lane 0 alone, I-type all-ones immediate.
        drive(0, 1'b1, 32'hFFF00093, IMM_I, 4'd3);
        drive(1, 1'b0, 32'h0, IMM_I, 4'd0);
        set_rdy(2'b11);
        cycle();
        drive(0, 1'b0, 32'h0, IMM_I, 4'd0);
        cycle();
        cycle();

        // Both lanes saturating.
        drive(0, 1'b1, 32'h123452B7, IMM_U, 4'd5);
        drive(1, 1'b1, 32'hFFDFF06F, IMM_J, 4'd9);
        for (int k = 0; k < 8; k++) cycle();
        drive(0, 1'b0, 32'h0, IMM_I, 4'd0);
        drive(1, 1'b0, 32'h0, IMM_I, 4'd0);
        cycle();

        // Lane 0 buffer full and not draining; lane 1 must keep flowing.
        drive(0, 1'b1, 32'h00A00513, IMM_I, 4'd1);
        drive(1, 1'b1, 32'h8000006F, IMM_J, 4'd2);
        set_rdy(2'b10);
        for (int k = 0; k < 6; k++) cycle();
        drive(0, 1'b0, 32'h0, IMM_I, 4'd0);
        drive(1, 1'b0, 32'h0, IMM_I, 4'd0);
        set_rdy(2'b11);
        cycle();

        // Flush against a lane-0 transfer and a lane-1 drain.
        drive(1, 1'b1, 32'hFE000EE3, IMM_B, 4'd7);
        set_rdy(2'b00);
        cycle();
        drive(1, 1'b0, 32'h0, IMM_I, 4'd0);
        drive(0, 1'b1, 32'hFE112E23, IMM_S, 4'd4);
        set_rdy(2'b10);
        flush_v = 1'b1;
        cycle();
        flush_v = 1'b0;
        drive(0, 1'b0, 32'h0, IMM_I, 4'd0);
        cycle();
        drive(0, 1'b1, 32'h0000D073, IMM_Z, 4'd6);
        drive(1, 1'b1, 32'h00000463, IMM_B, 4'd8);
        set_rdy(2'b11);
        cycle();
        cycle();

        // Random traffic, payload held while a request waits.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!held[d][i]) begin
                        valid_v[d][i] = ($urandom_range(0, 3) != 0);
                        instr_v[d][i] = $urandom;
                        sel_v[d][i]   = imm_t'(3'($urandom_range(0, 7)));
                        tag_v[d][i]   = 4'($urandom_range(0, 15));
                    end
                    rdy_v[d][i] = ($urandom_range(0, 3) != 0);
                end
            end
            flush_v = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush_v = 1'b0;

        // Fill both buffers, then reset mid-operation.
        drive(0, 1'b1, 32'hFFF00093, IMM_I, 4'd1);
        drive(1, 1'b1, 32'hFFDFF06F, IMM_J, 4'd2);
        set_rdy(2'b00);
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_rsp_valid_dut%0d", d), 32'(rv_o[d]), 32'h0);
            chk($sformatf("midrst_rsp_imm0_dut%0d", d), ri_o[d][0], 32'h0);
            chk($sformatf("midrst_rsp_imm1_dut%0d", d), ri_o[d][1], 32'h0);
            chk($sformatf("midrst_req_ready_dut%0d", d), 32'(rr_o[d]), 32'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_rdy(2'b11);
        cycle();
        cycle();
        drive(0, 1'b0, 32'h0, IMM_I, 4'd0);
        drive(1, 1'b0, 32'h0, IMM_I, 4'd0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_share_arb.md
# imm_share_arb

Two-requester arbiter that time-shares the single immediate generator between the decode lane (lane 0) and the early-branch target lane (lane 1) of the 3-stage RV32I pipeline. Each lane hands over an instruction word, an immediate format and a tag with a valid/ready handshake. The block grants one lane per cycle, round-robin or fixed-priority, and returns the sign/zero-extended immediate one cycle later. The result sits in that lane's one-entry response buffer.

## Interface
Parameters:
- TAG_W, 4, width of the requester tag carried through to the response
- FAIR, 1, 1 = round-robin between lanes; 0 = fixed priority, lane 0 always wins

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- req_valid  in  2  per-lane request valid
- req_ready  out  2  per-lane request accepted this cycle
- req_instr  in  2x32  per-lane instruction word
- req_sel  in  2x imm_t  per-lane immediate format (IMM_I/S/B/U/J/Z)
- req_tag  in  2xTAG_W  per-lane tag
- rsp_valid  out  2  per-lane response buffer full
- rsp_ready  in  2  per-lane consumer takes response
- rsp_imm  out  2x32  per-lane 32-bit immediate
- rsp_tag  out  2xTAG_W  per-lane tag echo
- conflict  out  1  pulse: both lanes eligible this cycle

## Operation
- Eligibility: lane i is eligible when req_valid[i] is high, flush is low, and its buffer can accept (!rsp_valid[i] | rsp_ready[i]).
- Grant:
  - Only eligible lanes compete; a lane blocked by a full buffer never stalls the other lane.
  - Exactly one or zero grants per cycle.
  - FAIR=1: if both lanes are eligible, the lane not recorded in last_grant wins.
  - FAIR=0: lane 0 wins.
- req_ready[i] = grant[i]. A transfer occurs when req_valid[i] & req_ready[i].
- On transfer: the granted lane's instr/sel drive the single imm_gen instance. Its output and req_tag are registered into rsp_imm[i]/rsp_tag[i], and rsp_valid[i] is set.
- Immediate formats: IMM_I/S/B/J sign-extend from instr[31]; IMM_U places instr[31:12] in the upper bits; IMM_Z zero-extends instr[19:15]. An undefined sel yields 32'h0.
- Drain: on rsp_valid[i] & rsp_ready[i] with no new transfer on lane i, rsp_valid[i] clears; rsp_imm/rsp_tag hold their last value.
- Simultaneous drain and new transfer on the same lane: the buffer reloads and rsp_valid stays 1.
- last_grant (1 bit) updates only on a transfer, to the granted lane. It is unchanged when idle and unchanged on flush.
- conflict = both lanes eligible (before the grant), combinational.
- flush:
  - clears rsp_valid[1:0] at the next edge;
  - forces req_ready=0 that cycle;
  - leaves rsp_imm/rsp_tag/last_grant unchanged.
  - flush wins over any drain or transfer in the same cycle.

## Timing
- Reset values (async assert, sync-safe deassert):
  - rsp_valid=2'b00, rsp_imm=0, rsp_tag=0, last_grant=1 (so lane 0 wins the first conflict), conflict=0.
  - req_ready=0 while rst_n is low.
- Latency: transfer at edge N → rsp_valid/rsp_imm valid after edge N, i.e. visible in cycle N+1.
- Throughput:
  - One immediate per cycle in total.
  - Each lane sustains 1/cycle when it is alone and its consumer keeps rsp_ready high.
  - Under FAIR=1 with both lanes saturating, the lanes alternate every cycle.
- Handshake rules:
  - req_ready may depend combinationally on req_valid of both lanes, rsp_ready and flush.
  - req_valid must not depend on req_ready.
  - Payload must be held stable while valid is high and ready is low.
  - rsp_valid, rsp_imm and rsp_tag come from flops only; there is no combinational path from req_* to rsp_*.
- Reset mid-operation: buffers empty immediately on rst_n low; pending transfers are lost, with no partial update.

## Structure
- imm_t (existing: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z) stays in rv32i_pkg. Add to rv32i_pkg:
  - localparam NUM_IMM_LANES = 2;
  - typedef lane_id_t (1 bit).
- Exactly one sub-module: one instance of the existing imm_gen, fed by a 2:1 mux on instr/sel selected by the grant.
- Arbitration, per-lane response buffers and last_grant live in imm_share_arb itself.

## Test plan
- Lane 0 only, instr 32'hFFF00093, sel IMM_I, tag 3 → req_ready[0]=1 that cycle; next cycle rsp_valid[0]=1, rsp_imm[0]=32'hFFFFFFFF, rsp_tag[0]=3; lane 1 untouched.
- Both lanes valid every cycle, FAIR=1; lane 0 sends 32'h123452B7/IMM_U, lane 1 sends 32'hFFDFF06F/IMM_J; rsp_ready=2'b11 →
  - grants go 0,1,0,1…;
  - conflict=1 each cycle;
  - rsp_imm[0]=32'h12345000, rsp_imm[1]=32'hFFFFFFFC.
- Same stimulus with FAIR=0 → lane 0 granted every cycle, req_ready[1] stays 0, rsp_valid[1] never rises.
- Lane 0 rsp_ready held 0 with its buffer full, lane 1 requesting → req_ready[0]=0, lane 1 granted every cycle, conflict=0, rsp_imm[0] stable.
- flush asserted in the same cycle as a lane-0 transfer and a lane-1 drain → req_ready=00, both rsp_valid=0 next cycle, last_grant unchanged.
- Assert rst_n low for one cycle while both buffers are full → rsp_valid=00 and rsp_imm=0 immediately; after release, the first conflict is won by lane 0.
